// File: rtl/if_id_pipe.sv
// IF->ID pipeline register with a one-entry skid buffer. Both handshake
// outputs come straight from flops, so id_ready never reaches if_ready combinationally.
module if_id_pipe #(
  parameter int                 ADDR_W      = 32,
  parameter int                 INST_W      = 32,
  parameter logic [INST_W-1:0]  BUBBLE_INST = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_inst,
  input  logic              if_excp,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic              id_excp,
  output logic [1:0]        occupancy
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic              excp;
  } entry_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t state, nxt;
  entry_t main_q, skid_q, in_e, bub;
  logic   in_xfer, out_xfer;

  assign in_e     = '{pc: if_pc, inst: if_inst, excp: if_excp};
  assign bub      = '{pc: '0, inst: BUBBLE_INST, excp: 1'b0};
  assign in_xfer  = if_valid && if_ready;
  assign out_xfer = id_valid && id_ready;

  assign id_pc    = main_q.pc;
  assign id_inst  = main_q.inst;
  assign id_excp  = main_q.excp;

  always_comb begin
    nxt = state;
    if (flush) nxt = EMPTY;
    else begin
      case (state)
        EMPTY:   if (in_xfer) nxt = ONE;
        ONE:     if (in_xfer && !out_xfer) nxt = TWO;
                 else if (!in_xfer && out_xfer) nxt = EMPTY;
        TWO:     if (out_xfer) nxt = ONE;
        default: nxt = EMPTY;
      endcase
    end
  end

  // main_q is reloaded with the bubble whenever the buffer drains, so the
  // id_* outputs read the bubble values directly from the register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      main_q    <= bub;
      skid_q    <= bub;
      id_valid  <= 1'b0;
      if_ready  <= 1'b1;
      occupancy <= 2'd0;
    end else begin
      state     <= nxt;
      id_valid  <= (nxt != EMPTY);
      if_ready  <= (nxt != TWO);
      occupancy <= nxt;
      if (flush) begin
        main_q <= bub;
      end else begin
        case (state)
          EMPTY: if (in_xfer) main_q <= in_e;
          ONE: begin
            if (in_xfer) begin
              if (out_xfer) main_q <= in_e;
              else          skid_q <= in_e;
            end else if (out_xfer) begin
              main_q <= bub;
            end
          end
          TWO:     if (out_xfer) main_q <= skid_q;
          default: main_q <= bub;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_id_pipe.sv
// Bench for if_id_pipe: FIFO-queue reference model checked every cycle,
// directed scenarios with literal expectations, then a random soak.
module tb_if_id_pipe;
  localparam int ADDR_W = 32;
  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] BUB = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst, flush, if_valid, if_ready, if_excp;
  logic              id_valid, id_ready, id_excp;
  logic [ADDR_W-1:0] if_pc, id_pc;
  logic [INST_W-1:0] if_inst, id_inst;
  logic [1:0]        occupancy;

  if_id_pipe #(.ADDR_W(ADDR_W), .INST_W(INST_W), .BUBBLE_INST(BUB)) dut (
    .clk(clk), .rst(rst), .flush(flush), .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_inst(if_inst), .if_excp(if_excp), .id_valid(id_valid),
    .id_ready(id_ready), .id_pc(id_pc), .id_inst(id_inst), .id_excp(id_excp),
    .occupancy(occupancy));

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic              excp;
  } ent_t;

  ent_t q[$];
  int   vectors = 0;
  int   errors  = 0;
  bit   en      = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference: the buffer is a FIFO of depth 2; ready means "not full".
  always @(posedge clk) begin
    bit can_in, do_out;
    can_in = (q.size() < 2);
    do_out = (q.size() > 0) && id_ready;
    if (rst || flush) q = {};
    else begin
      if (do_out) void'(q.pop_front());
      if (if_valid && can_in) q.push_back('{pc: if_pc, inst: if_inst, excp: if_excp});
    end
  end

  always @(negedge clk) begin
    if (en) begin
      chk("occupancy", 64'(occupancy), 64'(q.size()));
      chk("id_valid",  64'(id_valid),  64'(q.size() > 0));
      chk("if_ready",  64'(if_ready),  64'(q.size() < 2));
      chk("ready_vs_occ", 64'(if_ready), 64'(occupancy != 2'd2));
      if (q.size() > 0) begin
        chk("id_pc",   64'(id_pc),   64'(q[0].pc));
        chk("id_inst", 64'(id_inst), 64'(q[0].inst));
        chk("id_excp", 64'(id_excp), 64'(q[0].excp));
      end else begin
        chk("bub_pc",   64'(id_pc),   64'd0);
        chk("bub_inst", 64'(id_inst), 64'(BUB));
        chk("bub_excp", 64'(id_excp), 64'd0);
      end
    end
  end

  // Apply one cycle of inputs and return at the following falling edge.
  task automatic step(input bit r, input bit f, input bit v, input logic [ADDR_W-1:0] pc,
                      input bit x, input bit rdy);
    rst = r; flush = f; if_valid = v; if_pc = pc; if_inst = ~pc; if_excp = x; id_ready = rdy;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; if_valid = 1'b0; if_pc = '0; if_inst = '0;
    if_excp = 1'b0; id_ready = 1'b0;
    step(1, 0, 1, 32'hDEAD, 1, 1);
    step(1, 0, 1, 32'hBEEF, 0, 0);
    en = 1'b1;
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_valid", 64'(id_valid), 64'd0);
    chk("rst_ready", 64'(if_ready), 64'd1);
    chk("rst_inst", 64'(id_inst), 64'(BUB));

    // streaming: first transfer right after reset, one per cycle
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, 32'(4 * i), 0, 1);
      chk("stream_pc", 64'(id_pc), 64'(4 * i));
      chk("stream_occ", 64'(occupancy), 64'd1);
    end
    step(0, 0, 0, 0, 0, 1);

    // backpressure
    step(0, 0, 1, 32'h100, 0, 0);
    chk("bp_occ1", 64'(occupancy), 64'd1);
    step(0, 0, 1, 32'h104, 0, 0);
    chk("bp_occ2", 64'(occupancy), 64'd2);
    chk("bp_ready", 64'(if_ready), 64'd0);
    step(0, 0, 1, 32'h108, 0, 0);
    chk("bp_hold", 64'(id_pc), 64'h100);
    step(0, 0, 1, 32'h108, 0, 1);
    chk("bp_rel1", 64'(id_pc), 64'h104);
    step(0, 0, 1, 32'h108, 0, 1);
    chk("bp_rel2", 64'(id_pc), 64'h108);
    step(0, 0, 0, 0, 0, 1);

    // flush in TWO with an offered entry
    step(0, 0, 1, 32'h1F0, 0, 0);
    step(0, 0, 1, 32'h1F4, 0, 0);
    step(0, 1, 1, 32'h200, 0, 0);
    chk("fl_occ", 64'(occupancy), 64'd0);
    chk("fl_valid", 64'(id_valid), 64'd0);
    chk("fl_inst", 64'(id_inst), 64'(BUB));
    step(0, 0, 0, 0, 0, 1);
    chk("fl_gone", 64'(id_valid), 64'd0);

    // reset mid-stream in TWO with flush also high
    step(0, 0, 1, 32'h2F0, 0, 0);
    step(0, 0, 1, 32'h2F4, 0, 0);
    step(1, 1, 1, 32'h2F8, 1, 1);
    chk("mr_occ", 64'(occupancy), 64'd0);
    chk("mr_ready", 64'(if_ready), 64'd1);
    chk("mr_pc", 64'(id_pc), 64'd0);
    step(0, 0, 1, 32'h300, 0, 1);
    chk("mr_first", 64'(id_pc), 64'h300);

    // fault flag travels with its entry
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 32'(32'h38 + 4 * i), (i == 2), 1);
      chk("excp", 64'(id_excp), 64'(id_pc == 32'h40));
    end
    step(0, 0, 0, 0, 0, 1);

    // random soak
    for (int i = 0; i < 10000; i++) begin
      step(($urandom_range(0, 511) == 0), ($urandom_range(0, 31) == 0),
           $urandom_range(0, 1), $urandom, $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0);
    end

    en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
